// File: rtl/pwm_capture.sv
// rtl/pwm_capture.sv - PWM period and high-time capture
//
// Measures an external PWM waveform. Every full period (rise to rise) gives a
// period count and a high-time count in clock cycles. A missing rising edge
// for 2^CNT_W-1 cycles raises timeout and latches the input level.
//
// Ports:
//   clock       system clock, rising edge
//   reset       asynchronous active-high reset
//   enable      measurement enable; low forces IDLE and holds the outputs
//   pwm_in      asynchronous PWM input
//   period_out  last measured period in cycles
//   high_out    last measured high time in cycles
//   valid       one-cycle pulse when period_out/high_out are loaded
//   timeout     no rising edge within 2^CNT_W-1 cycles
//   level       synchronized input level latched on timeout
//
// Optional feature macro: PWM_CAPTURE_AVG_EN
//   When defined, four consecutive measurements are summed and the outputs
//   carry the truncated average, with valid pulsing once per group of four.

module pwm_capture #(
    parameter int CNT_W = 12
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] period_out,
    output logic [CNT_W-1:0] high_out,
    output logic             valid,
    output logic             timeout,
    output logic             level
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    // Last count before the period would exceed 2^CNT_W-1 cycles.
    localparam logic [CNT_W-1:0] CNT_LAST = {{(CNT_W-1){1'b1}}, 1'b0};

    state_t           state;
    state_t           state_next;
    logic             s1;
    logic             s2;
    logic             s3;
    logic             rise;
    logic             fall;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] high_tmp;
    logic             measuring;
    logic             at_limit;
    logic             meas_done;
    logic             to_hit;
    logic             high_hit;
    logic             cnt_clr;

    // Two-flop synchronizer plus a history flop for edge detection.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= pwm_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise      = s2 & ~s3;
    assign fall      = ~s2 & s3;
    assign cnt_inc   = cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    assign measuring = (state == HIGH) || (state == LOW);
    assign at_limit  = (cnt == CNT_LAST);

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. A rise on the limit cycle wins over the timeout so a
    // period of exactly 2^CNT_W-1 is still measured.
    always_comb begin
        state_next = state;
        if (!enable) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: if (rise) state_next = HIGH;
                HIGH: begin
                    if (at_limit)  state_next = IDLE;
                    else if (fall) state_next = LOW;
                end
                LOW: begin
                    if (rise)          state_next = HIGH;
                    else if (at_limit) state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Control strobes for the datapath registers.
    always_comb begin
        meas_done = 1'b0;
        to_hit    = 1'b0;
        high_hit  = 1'b0;
        cnt_clr   = 1'b1;
        if (enable && measuring) begin
            meas_done = (state == LOW) && rise;
            to_hit    = at_limit && !rise;
            high_hit  = (state == HIGH) && fall && !at_limit;
            cnt_clr   = meas_done || to_hit;
        end
    end

`ifdef PWM_CAPTURE_AVG_EN
    logic [CNT_W+1:0] sum_period;
    logic [CNT_W+1:0] sum_high;
    logic [CNT_W+1:0] sum_period_next;
    logic [CNT_W+1:0] sum_high_next;
    logic [1:0]       meas_cnt;

    assign sum_period_next = sum_period + {2'b00, cnt_inc};
    assign sum_high_next   = sum_high + {2'b00, high_tmp};
`endif

    // Datapath and output registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt        <= '0;
            high_tmp   <= '0;
            period_out <= '0;
            high_out   <= '0;
            valid      <= 1'b0;
            timeout    <= 1'b0;
            level      <= 1'b0;
`ifdef PWM_CAPTURE_AVG_EN
            sum_period <= '0;
            sum_high   <= '0;
            meas_cnt   <= '0;
`endif
        end else begin
            valid <= 1'b0;
            cnt   <= cnt_clr ? '0 : cnt_inc;

            if (high_hit) begin
                high_tmp <= cnt_inc;
            end

            if (to_hit) begin
                timeout <= 1'b1;
                level   <= s2;
            end

`ifdef PWM_CAPTURE_AVG_EN
            if (meas_done) begin
                timeout <= 1'b0;
                if (meas_cnt == 2'd3) begin
                    period_out <= sum_period_next[CNT_W+1:2];
                    high_out   <= sum_high_next[CNT_W+1:2];
                    valid      <= 1'b1;
                    sum_period <= '0;
                    sum_high   <= '0;
                    meas_cnt   <= '0;
                end else begin
                    sum_period <= sum_period_next;
                    sum_high   <= sum_high_next;
                    meas_cnt   <= meas_cnt + 2'd1;
                end
            end else if (to_hit || !enable) begin
                sum_period <= '0;
                sum_high   <= '0;
                meas_cnt   <= '0;
            end
`else
            if (meas_done) begin
                period_out <= cnt_inc;
                high_out   <= high_tmp;
                valid      <= 1'b1;
                timeout    <= 1'b0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// tb/tb_pwm_capture.sv - scoreboard bench for pwm_capture

module tb_pwm_capture;

    localparam int CNT_W   = 12;
    localparam int MAX_PER = 4095;

    logic             clock = 1'b0;
    logic             reset;
    logic             enable;
    logic             pwm_in;
    logic [CNT_W-1:0] period_out;
    logic [CNT_W-1:0] high_out;
    logic             valid;
    logic             timeout;
    logic             level;

    pwm_capture #(.CNT_W(CNT_W)) dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .pwm_in     (pwm_in),
        .period_out (period_out),
        .high_out   (high_out),
        .valid      (valid),
        .timeout    (timeout),
        .level      (level)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit kind;   // 0: measurement, 1: timeout
        int p;
        int h;
        bit lvl;
        int cyc;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;

    // Reference model state: rise-to-rise bookkeeping of the driven waveform.
    bit   aligned = 0;
    int   prev_p  = 0;
    int   prev_h  = 0;
    int   last_p  = 0;
    int   last_h  = 0;
    int   acc_p   = 0;
    int   acc_h   = 0;
    int   acc_n   = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic push_meas(int p, int h, int c);
        exp_t e;
`ifdef PWM_CAPTURE_AVG_EN
        acc_p += p;
        acc_h += h;
        acc_n++;
        if (acc_n < 4) return;
        p = acc_p / 4;
        h = acc_h / 4;
        acc_p = 0;
        acc_h = 0;
        acc_n = 0;
`endif
        e.kind = 0; e.p = p; e.h = h; e.lvl = 0; e.cyc = c;
        exp_q.push_back(e);
        last_p = p;
        last_h = h;
    endtask

    task automatic clear_acc();
        acc_p = 0;
        acc_h = 0;
        acc_n = 0;
    endtask

    // One PWM period starting with a rise: h cycles high, l cycles low.
    // dis drops enable for 20 cycles inside the low phase.
    task automatic pulse(int h, int l, bit dis);
        exp_t e;
        if (aligned) push_meas(prev_p, prev_h, cyc);
        if (h + l > MAX_PER) begin
            e.kind = 1; e.p = last_p; e.h = last_h; e.lvl = (h > MAX_PER); e.cyc = cyc;
            exp_q.push_back(e);
            aligned = 0;
            clear_acc();
        end else if (dis) begin
            aligned = 0;
            clear_acc();
        end else begin
            aligned = 1;
            prev_p  = h + l;
            prev_h  = h;
        end
        pwm_in = 1'b1;
        repeat (h) begin @(posedge clock); #1; end
        pwm_in = 1'b0;
        for (int i = 0; i < l; i++) begin
            if (dis && i == 5)  enable = 1'b0;
            if (dis && i == 25) enable = 1'b1;
            @(posedge clock); #1;
        end
    endtask

    // Monitor: pops the scoreboard on every valid pulse and timeout onset.
    logic to_prev = 1'b0;
    always @(negedge clock) begin
        if (reset) begin
            to_prev = 1'b0;
        end else begin
            if (valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid actual=1 expected=0 period=%0d high=%0d", period_out, high_out);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("valid_kind", 0, e.kind);
                    chk("period_out", period_out, e.p);
                    chk("high_out", high_out, e.h);
                    chk("timeout_clr", timeout, 0);
                    chk("valid_latency", cyc - e.cyc, 3);
                end
            end
            if (timeout && !to_prev) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_timeout actual=1 expected=0");
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("timeout_kind", 1, e.kind);
                    chk("timeout_level", level, e.lvl);
                    chk("timeout_hold_period", period_out, e.p);
                    chk("timeout_hold_high", high_out, e.h);
                end
            end
            to_prev = timeout;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog actual=expired required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        reset  = 1'b1;
        enable = 1'b0;
        pwm_in = 1'b0;
        repeat (3) begin @(posedge clock); #1; end
        chk("rst_period", period_out, 0);
        chk("rst_high", high_out, 0);
        chk("rst_valid", valid, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_level", level, 0);
        reset  = 1'b0;
        enable = 1'b1;
        repeat (5) begin @(posedge clock); #1; end

        // Steady 100/30.
        repeat (5) pulse(30, 70, 0);
        // Held high, then resume at period 50.
        pulse(5000, 10, 0);
        repeat (3) pulse(25, 25, 0);
        // Held low.
        pulse(20, 5000, 0);
        repeat (2) pulse(10, 40, 0);
        // Period 4095 measured, period 4096 times out.
        pulse(1, 4094, 0);
        pulse(1, 4094, 0);
        pulse(1, 4095, 0);
        repeat (3) pulse(30, 70, 0);
        // Enable dropped inside the low phase.
        pulse(30, 70, 1);
        repeat (4) pulse(30, 70, 0);
        // Minimum period and averaging pattern.
        repeat (4) pulse(1, 1, 0);
        pulse(10, 90, 0);
        pulse(10, 92, 0);
        pulse(12, 92, 0);
        pulse(12, 94, 0);
        pulse(30, 70, 0);
        // Random periods.
        for (int i = 0; i < 48; i++) begin
            pulse(int'($urandom_range(1, 200)), int'($urandom_range(1, 200)), 0);
        end
        pulse(30, 70, 0);

        repeat (10) begin @(posedge clock); #1; end
        chk("queue_drained", exp_q.size(), 0);

        // Asynchronous reset mid-period clears outputs immediately.
        reset = 1'b1;
        #1;
        chk("async_rst_period", period_out, 0);
        chk("async_rst_high", high_out, 0);
        chk("async_rst_valid", valid, 0);
        chk("async_rst_timeout", timeout, 0);
        chk("async_rst_level", level, 0);
        repeat (2) @(posedge clock);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
